mem_stage_lsu: RTL

Memory-stage load/store unit of the five-stage RISC-V pipeline. Takes the address and store data from the execute/memory pipeline register and performs byte/half/word accesses on a data-memory port with a valid/ready handshake. Produces the sign- or zero-extended `data_memory_RD_M` consumed by the memory/writeback register, and a `stall_M` that freezes the front of the pipeline while a memory access is outstanding. Detects misaligned or illegal accesses and memory timeouts.

---
 rtl/mem_stage_lsu.sv | 268 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_stage_lsu.sv
// -----------------------------------------------------------------------------
// mem_stage_lsu
//
// Memory-stage load/store unit of the five-stage RISC-V pipeline.
//
// The unit takes the address and store data from the E/M pipeline register.
// It performs byte, halfword and word accesses on a valid/ready data-memory
// port. It returns the extended load result to the M/W register. While an
// access waits on memory, it holds the front of the pipeline with stall_M.
//
// Ports:
//   clk, rst             single rising-edge clock, synchronous active-high reset
//   ALU_result_M         byte address of the access
//   write_data_M         store data (rs2)
//   ctrl_mem_read_M      load present in M
//   ctrl_mem_write_M     store present in M
//   funct3_M             access size / signedness
//   dmem_req/we/addr/wdata/be
//                        request to data memory (word address, lane-replicated
//                        data, byte enables)
//   dmem_ready           memory accepts/completes the request this cycle
//   dmem_rdata           read word, valid with dmem_ready
//   data_memory_RD_M     extended load result (combinational, completion cycle)
//   stall_M              hold F/D/E/M while an access is outstanding
//   addr_fault_M         misaligned / illegal funct3 / read+write conflict
//   bus_error_M          access aborted after TIMEOUT wait cycles
//
// Outputs are combinational on purpose. The load data and the stall must
// act in the same cycle that memory answers, so that a zero-wait access
// costs no stall cycle.
// -----------------------------------------------------------------------------
module mem_stage_lsu #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ALU_result_M,
  input  logic [31:0] write_data_M,
  input  logic        ctrl_mem_read_M,
  input  logic        ctrl_mem_write_M,
  input  logic [2:0]  funct3_M,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] data_memory_RD_M,
  output logic        stall_M,
  output logic        addr_fault_M,
  output logic        bus_error_M
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // funct3 encodings used by loads and stores
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic access_s;
  logic fault_s;

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------

  // True when the access must not reach memory: conflicting read+write,
  // unsupported size code for the direction, or a misaligned address.
  function automatic logic access_illegal(input logic       rd,
                                          input logic       wr,
                                          input logic [2:0] f3,
                                          input logic [1:0] a);
    logic bad;
    bad = 1'b0;
    if (rd && wr) begin
      bad = 1'b1;
    end else if (rd) begin
      case (f3)
        F3_B, F3_BU: bad = 1'b0;
        F3_H, F3_HU: bad = a[0];
        F3_W:        bad = (a != 2'b00);
        default:     bad = 1'b1;
      endcase
    end else if (wr) begin
      case (f3)
        F3_B:    bad = 1'b0;
        F3_H:    bad = a[0];
        F3_W:    bad = (a != 2'b00);
        default: bad = 1'b1;
      endcase
    end else begin
      bad = 1'b0;
    end
    return bad;
  endfunction

  // Byte enables for a store of the given size at the given byte offset.
  function automatic logic [3:0] store_be(input logic [2:0] f3,
                                          input logic [1:0] a);
    logic [3:0] be;
    case (f3)
      F3_B:    be = 4'b0001 << a;
      F3_H:    be = 4'b0011 << {a[1], 1'b0};
      F3_W:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Replicate the store data into every lane so the byte enables alone
  // choose where it lands in the word.
  function automatic logic [31:0] store_wdata(input logic [2:0]  f3,
                                              input logic [31:0] d);
    logic [31:0] w;
    case (f3)
      F3_B:    w = {4{d[7:0]}};
      F3_H:    w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

  // Select the addressed byte/half from the read word and extend it.
  function automatic logic [31:0] load_extract(input logic [2:0]  f3,
                                               input logic [1:0]  a,
                                               input logic [31:0] rdata);
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] r;
    case (a)
      2'b00:   byte_v = rdata[7:0];
      2'b01:   byte_v = rdata[15:8];
      2'b10:   byte_v = rdata[23:16];
      2'b11:   byte_v = rdata[31:24];
      default: byte_v = 8'h00;
    endcase
    if (a[1]) begin
      half_v = rdata[31:16];
    end else begin
      half_v = rdata[15:0];
    end
    case (f3)
      F3_B:    r = {{24{byte_v[7]}}, byte_v};
      F3_BU:   r = {24'h000000, byte_v};
      F3_H:    r = {{16{half_v[15]}}, half_v};
      F3_HU:   r = {16'h0000, half_v};
      F3_W:    r = rdata;
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------

  assign access_s   = ctrl_mem_read_M | ctrl_mem_write_M;
  assign fault_s    = access_s & access_illegal(ctrl_mem_read_M, ctrl_mem_write_M,
                                                funct3_M, ALU_result_M[1:0]);
  assign dmem_addr  = {ALU_result_M[31:2], 2'b00};
  assign dmem_wdata = store_wdata(funct3_M, write_data_M);

  // State and wait-counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= CNT_ZERO;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic and all handshake/status outputs
  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    dmem_req         = 1'b0;
    dmem_we          = 1'b0;
    dmem_be          = 4'b0000;
    stall_M          = 1'b0;
    addr_fault_M     = 1'b0;
    bus_error_M      = 1'b0;
    data_memory_RD_M = 32'h0000_0000;

    if (rst) begin
      // Every output stays at its zero default. Reset in WAIT therefore
      // drops the request in the same cycle.
      state_d = S_IDLE;
      cnt_d   = CNT_ZERO;
    end else if (!access_s) begin
      state_d = S_IDLE;
      cnt_d   = CNT_ZERO;
    end else if (fault_s) begin
      // A faulted access never reaches memory. The fault is reported at once,
      // and the pipeline moves on so the trap can be taken.
      addr_fault_M = 1'b1;
      state_d      = S_IDLE;
      cnt_d        = CNT_ZERO;
    end else begin
      dmem_req = 1'b1;
      dmem_we  = ctrl_mem_write_M;
      if (ctrl_mem_write_M) begin
        dmem_be = store_be(funct3_M, ALU_result_M[1:0]);
      end else begin
        dmem_be = 4'b1111;
      end

      case (state_q)
        S_IDLE: begin
          if (dmem_ready) begin
            state_d = S_IDLE;
            if (ctrl_mem_read_M) begin
              data_memory_RD_M = load_extract(funct3_M, ALU_result_M[1:0], dmem_rdata);
            end else begin
              data_memory_RD_M = 32'h0000_0000;
            end
          end else begin
            stall_M = 1'b1;
            state_d = S_WAIT;
            cnt_d   = CNT_ZERO;
          end
        end

        S_WAIT: begin
          // If ready and the timeout fall in the same cycle, ready wins.
          if (dmem_ready) begin
            state_d = S_IDLE;
            cnt_d   = CNT_ZERO;
            if (ctrl_mem_read_M) begin
              data_memory_RD_M = load_extract(funct3_M, ALU_result_M[1:0], dmem_rdata);
            end else begin
              data_memory_RD_M = 32'h0000_0000;
            end
          end else if (cnt_q == CNT_MAX) begin
            bus_error_M = 1'b1;
            state_d     = S_IDLE;
            cnt_d       = CNT_ZERO;
          end else begin
            stall_M = 1'b1;
            cnt_d   = cnt_q + CNT_ONE;
          end
        end

        default: begin
          state_d = S_IDLE;
          cnt_d   = CNT_ZERO;
        end
      endcase
    end
  end

endmodule
